// File: rtl/tcp_rx_datap.sv
// Receive-side protocol datapath for the slow TCP engine: one inbound header per flow,
// read-modify-write of per-flow RX state, then payload-store and scheduler commands.
package tcp_rx_datap_pkg;
  localparam int FLOWID_W         = 3;
  localparam int RX_PAYLOAD_PTR_W = 14;
  localparam int SEQ_NUM_W        = 32;
  localparam int TIMESTAMP_W      = 16;

  typedef struct packed {
    logic [SEQ_NUM_W-1:0] ack_num;
    logic [15:0]          window;
  } ack_state_struct;

  typedef struct packed {
    logic [SEQ_NUM_W-1:0] their_ack_num;
    ack_state_struct      our_ack_state;
  } smol_rx_state_struct;

  typedef struct packed {
    logic [SEQ_NUM_W-1:0] our_seq_num;
    logic [15:0]          their_win;
  } smol_tx_state_struct;

  typedef struct packed {
    logic [RX_PAYLOAD_PTR_W-1:0] addr;
    logic [RX_PAYLOAD_PTR_W:0]   size;
  } payload_buf_struct;

  typedef enum logic [1:0] {
    SCHED_NOP   = 2'd0,
    SCHED_SET   = 2'd1,
    SCHED_CLEAR = 2'd2
  } sched_flag_cmd_e;

  typedef struct packed {
    logic [FLOWID_W-1:0]    flowid;
    sched_flag_cmd_e        data_pend_cmd;
    logic [TIMESTAMP_W-1:0] data_pend_ts;
    sched_flag_cmd_e        ack_pend_cmd;
    logic [TIMESTAMP_W-1:0] ack_pend_ts;
    sched_flag_cmd_e        rt_pend_cmd;
    logic [TIMESTAMP_W-1:0] rt_pend_ts;
  } sched_cmd_struct;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_CALC    = 3'd3,
    ST_WR      = 3'd4,
    ST_CMD     = 3'd5
  } rx_datap_state_e;
endpackage

module tcp_rx_datap
  import tcp_rx_datap_pkg::*;
#(
  parameter int FLOWID_W         = tcp_rx_datap_pkg::FLOWID_W,
  parameter int RX_PAYLOAD_PTR_W = tcp_rx_datap_pkg::RX_PAYLOAD_PTR_W,
  parameter int SEQ_NUM_W        = tcp_rx_datap_pkg::SEQ_NUM_W
) (
  input  logic                        clk,
  input  logic                        rst_n,

  input  logic                        rx_pkt_val,
  output logic                        rx_pkt_rdy,
  input  logic [FLOWID_W-1:0]         rx_pkt_flowid,
  input  logic [SEQ_NUM_W-1:0]        rx_pkt_seq_num,
  input  logic [SEQ_NUM_W-1:0]        rx_pkt_ack_num,
  input  logic [7:0]                  rx_pkt_flags,
  input  logic [RX_PAYLOAD_PTR_W:0]   rx_pkt_payload_len,

  output logic                        state_rd_req_val,
  output logic [FLOWID_W-1:0]         state_rd_req_addr,
  input  logic                        state_rd_resp_val,
  input  smol_rx_state_struct         rx_state_rd_resp_data,
  input  smol_tx_state_struct         tx_state_rd_resp_data,
  input  logic [RX_PAYLOAD_PTR_W:0]   rx_head_ptr_rd_resp_data,

  output logic                        state_wr_req_val,
  output logic [FLOWID_W-1:0]         state_wr_req_addr,
  output smol_rx_state_struct         rx_state_wr_req_data,
  output logic [RX_PAYLOAD_PTR_W:0]   rx_tail_ptr_wr_req_data,

  output logic                        payload_cmd_val,
  input  logic                        payload_cmd_rdy,
  output payload_buf_struct           payload_cmd_data,

  output logic                        sched_update_val,
  input  logic                        sched_update_rdy,
  output sched_cmd_struct             sched_update_cmd,

  output rx_datap_state_e             dbg_state
);

  // Handshake rule for every val/rdy pair: a transfer happens on a rising clk edge where
  // both are high; once val is raised its data holds stable until that edge.

  localparam int PW = RX_PAYLOAD_PTR_W + 1;

  rx_datap_state_e            state;

  logic [FLOWID_W-1:0]        pkt_flowid;
  logic [SEQ_NUM_W-1:0]       pkt_seq;
  logic [SEQ_NUM_W-1:0]       pkt_ack;
  logic                       pkt_ack_flag;
  logic [PW-1:0]              pkt_len;

  smol_rx_state_struct        rx_st;
  logic [SEQ_NUM_W-1:0]       our_seq;
  logic [PW-1:0]              head_ptr;
  logic                       accept_q;

  logic [PW-1:0]              used;
  logic [PW-1:0]              free;
  logic [SEQ_NUM_W-1:0]       ack_delta;
  logic [SEQ_NUM_W-1:0]       ack_window;
  logic                       accept;
  logic                       ack_ok;
  logic [SEQ_NUM_W-1:0]       new_their_ack;
  logic                       sched_need;
  logic                       payload_busy;
  logic                       sched_busy;

  logic                       unused_ok;
  assign unused_ok = ^{rx_pkt_flags[7:5], rx_pkt_flags[3:0], tx_state_rd_resp_data.their_win};

  assign rx_pkt_rdy        = (state == ST_IDLE);
  assign state_rd_req_addr = pkt_flowid;
  assign state_wr_req_addr = pkt_flowid;
  assign dbg_state         = state;

  // Acceptance and ACK-advance decisions; all operands are latched, so this is stable in CALC.
  always_comb begin
    used          = rx_st.their_ack_num[PW-1:0] - head_ptr;
    free          = {1'b1, {RX_PAYLOAD_PTR_W{1'b0}}} - used;
    accept        = (pkt_seq == rx_st.their_ack_num) && (pkt_len != '0) && (pkt_len <= free);
    ack_delta     = pkt_ack - rx_st.our_ack_state.ack_num;
    ack_window    = our_seq - rx_st.our_ack_state.ack_num;
    ack_ok        = pkt_ack_flag && (ack_delta != '0) && (ack_delta <= ack_window);
    new_their_ack = rx_st.their_ack_num + (accept ? SEQ_NUM_W'(pkt_len) : '0);
  end

  assign sched_need   = (sched_update_cmd.ack_pend_cmd != SCHED_NOP) ||
                        (sched_update_cmd.rt_pend_cmd  != SCHED_NOP) ||
                        (sched_update_cmd.data_pend_cmd != SCHED_NOP);
  assign payload_busy = payload_cmd_val && !payload_cmd_rdy;
  assign sched_busy   = sched_update_val && !sched_update_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= ST_IDLE;
      pkt_flowid              <= '0;
      pkt_seq                 <= '0;
      pkt_ack                 <= '0;
      pkt_ack_flag            <= 1'b0;
      pkt_len                 <= '0;
      rx_st                   <= '0;
      our_seq                 <= '0;
      head_ptr                <= '0;
      accept_q                <= 1'b0;
      state_rd_req_val        <= 1'b0;
      state_wr_req_val        <= 1'b0;
      rx_state_wr_req_data    <= '0;
      rx_tail_ptr_wr_req_data <= '0;
      payload_cmd_val         <= 1'b0;
      payload_cmd_data        <= '0;
      sched_update_val        <= 1'b0;
      sched_update_cmd        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_pkt_val) begin
            pkt_flowid       <= rx_pkt_flowid;
            pkt_seq          <= rx_pkt_seq_num;
            pkt_ack          <= rx_pkt_ack_num;
            pkt_ack_flag     <= rx_pkt_flags[4];
            pkt_len          <= rx_pkt_payload_len;
            state_rd_req_val <= 1'b1;
            state            <= ST_RD_REQ;
          end
        end
        ST_RD_REQ: begin
          state_rd_req_val <= 1'b0;
          state            <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (state_rd_resp_val) begin
            rx_st    <= rx_state_rd_resp_data;
            our_seq  <= tx_state_rd_resp_data.our_seq_num;
            head_ptr <= rx_head_ptr_rd_resp_data;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          state_wr_req_val                          <= 1'b1;
          rx_state_wr_req_data                      <= rx_st;
          rx_state_wr_req_data.their_ack_num        <= new_their_ack;
          rx_state_wr_req_data.our_ack_state.ack_num <= ack_ok ? pkt_ack : rx_st.our_ack_state.ack_num;
          rx_tail_ptr_wr_req_data                   <= new_their_ack[PW-1:0];
          accept_q                                  <= accept;
          payload_cmd_data.addr                     <= pkt_seq[RX_PAYLOAD_PTR_W-1:0];
          payload_cmd_data.size                     <= pkt_len;
          sched_update_cmd                          <= '0;
          sched_update_cmd.flowid                   <= pkt_flowid;
          // A non-empty segment always re-arms an ACK, so drops and gaps produce a dup ACK.
          sched_update_cmd.ack_pend_cmd             <= (pkt_len != '0) ? SCHED_SET : SCHED_NOP;
          sched_update_cmd.rt_pend_cmd              <= (ack_ok && (pkt_ack == our_seq)) ?
                                                       SCHED_CLEAR : SCHED_NOP;
          state                                     <= ST_WR;
        end
        ST_WR: begin
          state_wr_req_val <= 1'b0;
          payload_cmd_val  <= accept_q;
          sched_update_val <= sched_need;
          state            <= ST_CMD;
        end
        ST_CMD: begin
          if (payload_cmd_val && payload_cmd_rdy) payload_cmd_val <= 1'b0;
          if (sched_update_val && sched_update_rdy) sched_update_val <= 1'b0;
          if (!payload_busy && !sched_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
